// File: rtl/rv_muldiv_unit_if.sv
// Request/response bundle for the iterative M-extension unit.
// Decode drives the master side; the unit is the slave.
interface rv_muldiv_unit_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_op;
  logic [XLEN-1:0]  in_a;
  logic [XLEN-1:0]  in_b;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_result;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, in_op, in_a, in_b, in_tag,
    output out_ready,
    input  in_ready,
    input  out_valid, out_result, out_tag
  );

  modport slave (
    input  in_valid, in_op, in_a, in_b, in_tag,
    input  out_ready,
    output in_ready,
    output out_valid, out_result, out_tag
  );
endinterface

// File: rtl/rv_muldiv_unit.sv
// Iterative RV32M/RV64M multiply/divide unit, one bit per cycle
// on operand magnitudes with a final sign correction.
module rv_muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  rv_muldiv_unit_if.slave  bus,
  output logic             busy
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CW-1:0]    r_cnt;
  logic [2:0]       r_op;
  logic [XLEN-1:0]  r_hi;
  logic [XLEN-1:0]  r_lo;
  logic [XLEN-1:0]  r_mcand;
  logic [XLEN-1:0]  r_result;
  logic [TAG_W-1:0] r_tag;
  logic             r_neg_q;
  logic             r_neg_r;

  logic             w_accept;
  logic             w_last;
  logic             w_is_div;
  logic             w_a_sgn;
  logic             w_b_sgn;
  logic             w_a_neg;
  logic             w_b_neg;
  logic [XLEN-1:0]  w_a_mag;
  logic [XLEN-1:0]  w_b_mag;
  logic             w_b_zero;
  logic             w_ovf;
  logic             w_fast;
  logic [XLEN-1:0]  w_fast_res;

  logic [XLEN:0]    w_sum;
  logic [XLEN-1:0]  w_mul_hi;
  logic [XLEN-1:0]  w_mul_lo;
  logic [XLEN:0]    w_sh;
  logic             w_ge;
  logic [XLEN-1:0]  w_div_hi;
  logic [XLEN-1:0]  w_div_lo;
  logic [XLEN-1:0]  w_hi_nxt;
  logic [XLEN-1:0]  w_lo_nxt;
  logic [2*XLEN-1:0] w_prod;
  logic [2*XLEN-1:0] w_prod_s;
  logic [XLEN-1:0]  w_quo;
  logic [XLEN-1:0]  w_rem;
  logic [XLEN-1:0]  w_final;

  assign bus.in_ready   = (r_state == IDLE);
  assign bus.out_valid  = (r_state == DONE);
  assign bus.out_result = r_result;
  assign bus.out_tag    = r_tag;
  assign busy           = (r_state != IDLE);

  assign w_accept = bus.in_valid && bus.in_ready && !flush;
  assign w_last   = (r_cnt == CW'(XLEN-1));

  // Operand signedness and magnitudes for the incoming op.
  always_comb begin
    w_is_div = bus.in_op[2];
    w_a_sgn  = w_is_div ? !bus.in_op[0]
                        : (bus.in_op[1:0] != 2'b11);
    w_b_sgn  = w_is_div ? !bus.in_op[0]
                        : !bus.in_op[1];
    w_a_neg  = w_a_sgn && bus.in_a[XLEN-1];
    w_b_neg  = w_b_sgn && bus.in_b[XLEN-1];
    w_a_mag  = w_a_neg ? -bus.in_a : bus.in_a;
    w_b_mag  = w_b_neg ? -bus.in_b : bus.in_b;
    w_b_zero = (bus.in_b == '0);
    w_ovf    = w_is_div && !bus.in_op[0]
            && (bus.in_a == {1'b1, {(XLEN-1){1'b0}}})
            && (&bus.in_b);
    w_fast   = w_is_div && (w_b_zero || w_ovf);
  end

  // Results of the divide special cases that skip iteration.
  always_comb begin
    w_fast_res = '0;
    unique case (1'b1)
      w_b_zero && !bus.in_op[1]: w_fast_res = '1;
      w_b_zero &&  bus.in_op[1]: w_fast_res = bus.in_a;
      w_ovf    && !bus.in_op[1]: w_fast_res = bus.in_a;
      default:                   w_fast_res = '0;
    endcase
  end

  // One shift-add or one restoring-subtract step per cycle.
  always_comb begin
    w_sum    = {1'b0, r_hi}
             + (r_lo[0] ? {1'b0, r_mcand} : '0);
    w_mul_hi = w_sum[XLEN:1];
    w_mul_lo = {w_sum[0], r_lo[XLEN-1:1]};
    w_sh     = {r_hi, r_lo[XLEN-1]};
    w_ge     = (w_sh >= {1'b0, r_mcand});
    w_div_hi = w_ge ? XLEN'(w_sh - {1'b0, r_mcand})
                    : w_sh[XLEN-1:0];
    w_div_lo = {r_lo[XLEN-2:0], w_ge};
    w_hi_nxt = r_op[2] ? w_div_hi : w_mul_hi;
    w_lo_nxt = r_op[2] ? w_div_lo : w_mul_lo;
  end

  // Sign correction and result selection on the last step.
  always_comb begin
    w_prod   = {w_hi_nxt, w_lo_nxt};
    w_prod_s = r_neg_q ? -w_prod : w_prod;
    w_quo    = r_neg_q ? -w_lo_nxt : w_lo_nxt;
    w_rem    = r_neg_r ? -w_hi_nxt : w_hi_nxt;
    w_final  = '0;
    unique case (1'b1)
      !r_op[2] && (r_op[1:0] == 2'b00):
        w_final = w_prod_s[XLEN-1:0];
      !r_op[2] && (r_op[1:0] != 2'b00):
        w_final = w_prod_s[2*XLEN-1:XLEN];
      r_op[2] && !r_op[1]:
        w_final = w_quo;
      r_op[2] && r_op[1]:
        w_final = w_rem;
      default:
        w_final = '0;
    endcase
  end

  // Next-state logic; flush overrides every transition.
  always_comb begin
    w_state_nxt = r_state;
    if (flush) begin
      w_state_nxt = IDLE;
    end else begin
      unique case (r_state)
        IDLE: if (w_accept)
                w_state_nxt = w_fast ? DONE : BUSY;
        BUSY: if (w_last)
                w_state_nxt = DONE;
        DONE: if (bus.out_ready)
                w_state_nxt = IDLE;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Operand capture, iteration and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_op     <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_mcand  <= '0;
      r_result <= '0;
      r_tag    <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
    end else if (flush) begin
      r_cnt <= '0;
    end else if (w_accept) begin
      r_cnt   <= '0;
      r_op    <= bus.in_op;
      r_tag   <= bus.in_tag;
      r_hi    <= '0;
      r_lo    <= w_is_div ? w_a_mag : w_b_mag;
      r_mcand <= w_is_div ? w_b_mag : w_a_mag;
      r_neg_q <= w_a_neg ^ w_b_neg;
      r_neg_r <= w_a_neg;
      if (w_fast) r_result <= w_fast_res;
    end else if (r_state == BUSY) begin
      r_hi <= w_hi_nxt;
      r_lo <= w_lo_nxt;
      if (w_last) begin
        r_cnt    <= '0;
        r_result <= w_final;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

endmodule
